// File: rtl/ramctrl.sv
// ramctrl: byte-serial RAM port arbiter between datactrl (1/2/4-byte loads
// and stores) and the instruction cache (4-byte fetches). One RAM byte moves
// per cycle; read bytes are assembled little-endian and loads are extended.
// Data requests always win over a simultaneous fetch.
module ramctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_rst_in,
  input  logic              datactrl_ramctrl_data_en_in,
  input  logic              datactrl_ramctrl_data_rw_in,
  input  logic              datactrl_ramctrl_data_sgn_in,
  input  logic [2:0]        datactrl_ramctrl_data_width_in,
  input  logic [ADDR_W-1:0] datactrl_ramctrl_data_addr_in,
  input  logic [DATA_W-1:0] datactrl_ramctrl_data_data_in,
  output logic              ramctrl_datactrl_data_rdy_out,
  output logic [DATA_W-1:0] ramctrl_datactrl_data_data_out,
  input  logic              icache_ramctrl_en_in,
  input  logic [ADDR_W-1:0] icache_ramctrl_addr_in,
  output logic              ramctrl_icache_rdy_out,
  output logic [DATA_W-1:0] ramctrl_icache_data_out,
  input  logic [7:0]        mem_din_in,
  output logic [7:0]        mem_dout_out,
  output logic [ADDR_W-1:0] mem_a_out,
  output logic              mem_wr_out
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [2:0]        width;
  logic              sgn;
  logic              src_fetch;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  // Read bytes shift in from the top, so after N samples they occupy the top N lanes.
  logic [DATA_W-9:0] rbuf;
  logic [DATA_W-1:0] assembled;
  logic [2:0]        cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              accept_data;
  logic              accept_fetch;
  logic              rd_sample;
  logic              wr_advance;

  // Width encodings other than 1 and 2 behave as a full word.
  function automatic logic [2:0] norm_width(input logic [2:0] w);
    case (w)
      3'd1:    norm_width = 3'd1;
      3'd2:    norm_width = 3'd2;
      default: norm_width = 3'd4;
    endcase
  endfunction

  // Extend a top-lane-aligned read word according to width and sign flag.
  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] word,
                                                    input logic [2:0] w, input logic s);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[DATA_W-1 -: 8];
    h = word[DATA_W-1 -: 16];
    case (w)
      3'd1:    extend_load = s ? DATA_W'(b) : DATA_W'($unsigned(b));
      3'd2:    extend_load = s ? DATA_W'(h) : DATA_W'($unsigned(h));
      default: extend_load = word;
    endcase
  endfunction

  // Request acceptance, byte stepping and the word formed by the byte on mem_din_in.
  always_comb begin
    cnt_nxt      = cnt + 3'd1;
    addr_nxt     = addr + ADDR_W'(cnt_nxt);
    assembled    = {mem_din_in, rbuf};
    accept_data  = rdy_in && (state == IDLE) && !rob_rst_in && datactrl_ramctrl_data_en_in;
    accept_fetch = rdy_in && (state == IDLE) && !rob_rst_in && !datactrl_ramctrl_data_en_in
                   && icache_ramctrl_en_in;
    rd_sample    = rdy_in && (state == READ) && !rob_rst_in && (cnt != 3'd0);
    wr_advance   = rdy_in && (state == WRITE) && (cnt_nxt != width);
  end

  // Request datapath: latched address, store byte queue and read byte buffer.
  always_ff @(posedge clk_in) begin
    if (accept_data) begin
      addr  <= datactrl_ramctrl_data_addr_in;
      wdata <= datactrl_ramctrl_data_data_in >> 8;
    end else if (accept_fetch) begin
      addr <= icache_ramctrl_addr_in;
    end else if (wr_advance) begin
      wdata <= wdata >> 8;
    end
    if (rd_sample) rbuf <= assembled[DATA_W-1:8];
  end

  // Arbiter FSM with registered RAM bus and completion outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state                          <= IDLE;
      cnt                            <= 3'd0;
      width                          <= 3'd4;
      sgn                            <= 1'b0;
      src_fetch                      <= 1'b0;
      ramctrl_datactrl_data_rdy_out  <= 1'b0;
      ramctrl_datactrl_data_data_out <= '0;
      ramctrl_icache_rdy_out         <= 1'b0;
      ramctrl_icache_data_out        <= '0;
      mem_dout_out                   <= 8'h00;
      mem_a_out                      <= '0;
      mem_wr_out                     <= 1'b0;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          if (accept_data) begin
            cnt       <= 3'd0;
            width     <= norm_width(datactrl_ramctrl_data_width_in);
            sgn       <= datactrl_ramctrl_data_sgn_in;
            src_fetch <= 1'b0;
            mem_a_out <= datactrl_ramctrl_data_addr_in;
            if (datactrl_ramctrl_data_rw_in) begin
              state        <= WRITE;
              mem_wr_out   <= 1'b1;
              mem_dout_out <= datactrl_ramctrl_data_data_in[7:0];
            end else begin
              state <= READ;
            end
          end else if (accept_fetch) begin
            cnt       <= 3'd0;
            width     <= 3'd4;
            sgn       <= 1'b0;
            src_fetch <= 1'b1;
            mem_a_out <= icache_ramctrl_addr_in;
            state     <= READ;
          end
        end
        READ: begin
          if (rob_rst_in) begin
            state      <= IDLE;
            mem_wr_out <= 1'b0;
          end else if (cnt == width) begin
            state <= DONE;
            if (src_fetch) begin
              ramctrl_icache_rdy_out  <= 1'b1;
              ramctrl_icache_data_out <= assembled;
            end else begin
              ramctrl_datactrl_data_rdy_out  <= 1'b1;
              ramctrl_datactrl_data_data_out <= extend_load(assembled, width, sgn);
            end
          end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt != width) mem_a_out <= addr_nxt;
          end
        end
        WRITE: begin
          // A committed store is never cut short by a flush.
          if (cnt_nxt == width) begin
            state                         <= DONE;
            mem_wr_out                    <= 1'b0;
            ramctrl_datactrl_data_rdy_out <= 1'b1;
          end else begin
            cnt          <= cnt_nxt;
            mem_a_out    <= addr_nxt;
            mem_dout_out <= wdata[7:0];
          end
        end
        default: begin
          // Turnaround cycle keeps a still-asserted enable from being re-accepted.
          ramctrl_datactrl_data_rdy_out <= 1'b0;
          ramctrl_icache_rdy_out        <= 1'b0;
          state                         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ramctrl.sv
// Testbench for ramctrl: byte-wide RAM model plus a transaction-level
// reference memory; directed corner cases followed by randomized traffic.
`timescale 1ns/1ps
module tb_ramctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        rob_rst = 1'b0;
  logic        d_en = 1'b0;
  logic        d_rw = 1'b0;
  logic        d_sgn = 1'b0;
  logic [2:0]  d_width = 3'd0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_rdy;
  logic [31:0] d_rdata;
  logic        f_en = 1'b0;
  logic [31:0] f_addr = 32'h0;
  logic        f_rdy;
  logic [31:0] f_data;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_cmp = 0;
  int n_bad = 0;
  int both_high = 0;
  int back_to_back = 0;
  bit prev_rdy = 1'b0;

  logic [7:0]  ram [65536];
  bit          written [65536];
  logic [7:0]  ref_mem [65536];
  logic [31:0] wr_a [$];
  logic [7:0]  wr_d [$];

  always #5 clk = ~clk;

  ramctrl dut (
    .clk_in                         (clk),
    .rst_in                         (rst_n),
    .rdy_in                         (rdy),
    .rob_rst_in                     (rob_rst),
    .datactrl_ramctrl_data_en_in    (d_en),
    .datactrl_ramctrl_data_rw_in    (d_rw),
    .datactrl_ramctrl_data_sgn_in   (d_sgn),
    .datactrl_ramctrl_data_width_in (d_width),
    .datactrl_ramctrl_data_addr_in  (d_addr),
    .datactrl_ramctrl_data_data_in  (d_wdata),
    .ramctrl_datactrl_data_rdy_out  (d_rdy),
    .ramctrl_datactrl_data_data_out (d_rdata),
    .icache_ramctrl_en_in           (f_en),
    .icache_ramctrl_addr_in         (f_addr),
    .ramctrl_icache_rdy_out         (f_rdy),
    .ramctrl_icache_data_out        (f_data),
    .mem_din_in                     (mem_din),
    .mem_dout_out                   (mem_dout),
    .mem_a_out                      (mem_a),
    .mem_wr_out                     (mem_wr)
  );

  // Power-up contents of every RAM location.
  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return 8'(a * 16'd29) ^ a[15:8] ^ 8'hA5;
  endfunction

  // RAM model: read data one cycle after the address, writes on the edge.
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= written[mem_a[15:0]] ? ram[mem_a[15:0]] : init_byte(mem_a[15:0]);
      if (mem_wr) begin
        ram[mem_a[15:0]]     <= mem_dout;
        written[mem_a[15:0]] <= 1'b1;
      end
    end
  end

  // Handshake rule monitor on the completion pulses.
  always @(negedge clk) begin
    if (d_rdy && f_rdy) both_high++;
    if (rst_n && prev_rdy && (d_rdy || f_rdy)) back_to_back++;
    prev_rdy = d_rdy || f_rdy;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int eff_width(input logic [2:0] w);
    return (w == 3'd1) ? 1 : (w == 3'd2) ? 2 : 4;
  endfunction

  // Reference load: little-endian sum of bytes, two's-complement fold when signed.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input logic s);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[16'(a + 32'(i))]) << (8 * i);
    if (s && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input int n);
    for (int i = 0; i < n; i++) ref_mem[16'(a + 32'(i))] = 8'(wd >> (8 * i));
  endtask

  task automatic set_d(input logic rw, input logic s, input logic [2:0] w,
                       input logic [31:0] a, input logic [31:0] wd);
    d_rw = rw; d_sgn = s; d_width = w; d_addr = a; d_wdata = wd;
  endtask

  task automatic check_writes(input logic [31:0] a, input logic [31:0] wd, input int n);
    chk("wr_count", 64'(wr_a.size()), 64'(n));
    for (int i = 0; i < n; i++)
      if (i < wr_a.size())
        chk("wr_byte", {wr_a[i], wr_d[i]}, {a + 32'(i), 8'(wd >> (8 * i))});
  endtask

  // Raise the selected enables and follow both channels until their pulses.
  // flush_c: loop step after which rob_rst (and icache flush) is held for one cycle.
  // stall_c: loop step after which rdy is held low for three cycles.
  task automatic run(input bit do_d, input bit do_f, input int flush_c, input int stall_c,
                     output bit d_seen, output int d_lat, output logic [31:0] d_res,
                     output bit f_seen, output int f_lat, output logic [31:0] f_res);
    logic [31:0] a_hold = 32'h0;
    int limit = 60;
    d_seen = 0; f_seen = 0; d_lat = -1; f_lat = -1; d_res = 32'h0; f_res = 32'h0;
    wr_a.delete(); wr_d.delete();
    @(negedge clk);
    d_en = do_d;
    f_en = do_f;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk); #1;
      rob_rst = (c == flush_c);
      rdy = !(c >= stall_c && c < stall_c + 3);
      if (c == flush_c) begin f_en = 1'b0; limit = c + 8; end
      if (c == stall_c) a_hold = mem_a;
      if (c == stall_c + 2) chk("stall_addr_hold", mem_a, a_hold);
      if (rdy && mem_wr) begin wr_a.push_back(mem_a); wr_d.push_back(mem_dout); end
      if (do_d && !d_seen && d_rdy) begin d_seen = 1; d_lat = c - 1; d_res = d_rdata; d_en = 1'b0; end
      if (do_f && !f_seen && f_rdy) begin f_seen = 1; f_lat = c - 1; f_res = f_data; f_en = 1'b0; end
      if ((d_seen || !do_d) && (f_seen || !do_f)) break;
    end
    rob_rst = 1'b0;
    rdy = 1'b1;
    d_en = 1'b0;
    f_en = 1'b0;
    @(posedge clk); #1;
    chk("rdy_pulse_drop", {d_rdy, f_rdy}, 2'b00);
  endtask

  initial begin
    bit ds, fs;
    int dl, fl, n, kind;
    logic [31:0] dr, fr, a, wd, fa;
    logic [2:0] w;
    logic s;

    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data_rdy", d_rdy, 0);
    chk("rst_icache_rdy", f_rdy, 0);
    chk("rst_data_out", d_rdata, 0);
    chk("rst_icache_out", f_data, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", mem_dout, 0);
    chk("rst_mem_wr", mem_wr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed: set up memory through stores
    set_d(1, 0, 3'd4, 32'h100, 32'h44332211);
    run(1, 0, -1, -100, ds, dl, dr, fs, fl, fr);
    chk("sw_lat", 64'(dl), 4);
    check_writes(32'h100, 32'h44332211, 4);
    ref_store(32'h100, 32'h44332211, 4);
    set_d(1, 0, 3'd2, 32'h200, 32'h0000FF80);
    run(1, 0, -1, -100, ds, dl, dr, fs, fl, fr);
    ref_store(32'h200, 32'h0000FF80, 2);

    set_d(0, 0, 3'd4, 32'h100, 32'h0);
    run(1, 0, -1, -100, ds, dl, dr, fs, fl, fr);
    chk("lw_data", dr, 32'h44332211);
    chk("lw_lat", 64'(dl), 5);
    set_d(0, 1, 3'd1, 32'h200, 32'h0);
    run(1, 0, -1, -100, ds, dl, dr, fs, fl, fr);
    chk("lb_data", dr, 32'hFFFFFF80);
    chk("lb_lat", 64'(dl), 2);
    set_d(0, 0, 3'd2, 32'h200, 32'h0);
    run(1, 0, -1, -100, ds, dl, dr, fs, fl, fr);
    chk("lhu_data", dr, 32'h0000FF80);
    chk("lhu_lat", 64'(dl), 3);
    set_d(0, 0, 3'd3, 32'h100, 32'h0);
    run(1, 0, -1, -100, ds, dl, dr, fs, fl, fr);
    chk("illegal_w_data", dr, 32'h44332211);
    chk("illegal_w_lat", 64'(dl), 5);

    set_d(1, 0, 3'd2, 32'h300, 32'h0000ABCD);
    run(1, 0, -1, -100, ds, dl, dr, fs, fl, fr);
    chk("sh_lat", 64'(dl), 2);
    check_writes(32'h300, 32'h0000ABCD, 2);
    ref_store(32'h300, 32'h0000ABCD, 2);

    // Data and fetch raised together: data first, fetch after turnaround
    set_d(0, 0, 3'd4, 32'h100, 32'h0);
    f_addr = 32'h200;
    run(1, 1, -1, -100, ds, dl, dr, fs, fl, fr);
    chk("both_data", dr, 32'h44332211);
    chk("both_data_lat", 64'(dl), 5);
    chk("both_fetch_data", fr, ref_load(32'h200, 4, 0));
    chk("both_fetch_lat", 64'(fl), 12);

    // Fetch flushed during byte 2
    f_addr = 32'h400;
    run(0, 1, 3, -100, ds, dl, dr, fs, fl, fr);
    chk("abort_no_rdy", fs, 0);
    chk("abort_mem_wr", mem_wr, 0);
    set_d(0, 0, 3'd4, 32'h100, 32'h0);
    run(1, 0, -1, -100, ds, dl, dr, fs, fl, fr);
    chk("after_abort_lat", 64'(dl), 5);

    // Flush during a store is ignored
    set_d(1, 0, 3'd4, 32'h500, 32'h8899AABB);
    run(1, 0, 3, -100, ds, dl, dr, fs, fl, fr);
    chk("sw_flush_rdy", ds, 1);
    chk("sw_flush_lat", 64'(dl), 4);
    check_writes(32'h500, 32'h8899AABB, 4);
    ref_store(32'h500, 32'h8899AABB, 4);

    // Global enable low for three cycles mid-load
    set_d(0, 0, 3'd4, 32'h500, 32'h0);
    run(1, 0, -1, 3, ds, dl, dr, fs, fl, fr);
    chk("stall_data", dr, 32'h8899AABB);
    chk("stall_lat", 64'(dl), 8);

    // Address wrap
    set_d(1, 0, 3'd4, 32'hFFFFFFFE, 32'hC0FFEE11);
    run(1, 0, -1, -100, ds, dl, dr, fs, fl, fr);
    check_writes(32'hFFFFFFFE, 32'hC0FFEE11, 4);
    ref_store(32'hFFFFFFFE, 32'hC0FFEE11, 4);
    set_d(0, 0, 3'd4, 32'hFFFFFFFE, 32'h0);
    run(1, 0, -1, -100, ds, dl, dr, fs, fl, fr);
    chk("wrap_data", dr, 32'hC0FFEE11);

    // Asynchronous reset in the middle of a store
    set_d(1, 0, 3'd4, 32'h9000, 32'h12345678);
    @(negedge clk);
    d_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pre_wr", mem_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_wr", mem_wr, 0);
    chk("async_rst_a", mem_a, 0);
    chk("async_rst_dout", mem_dout, 0);
    chk("async_rst_rdy", d_rdy, 0);
    d_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_d(0, 0, 3'd4, 32'h100, 32'h0);
    run(1, 0, -1, -100, ds, dl, dr, fs, fl, fr);
    chk("post_rst_data", dr, 32'h44332211);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7)))
                                       : 32'($urandom_range(0, 32'h8FF0));
      fa = 32'($urandom_range(0, 32'h8FF0));
      w  = 3'($urandom_range(0, 7));
      s  = 1'($urandom);
      wd = $urandom;
      n  = eff_width(w);
      if (kind == 2) begin
        f_addr = fa;
        run(0, 1, -1, -100, ds, dl, dr, fs, fl, fr);
        chk("rnd_fetch_data", fr, ref_load(fa, 4, 0));
        chk("rnd_fetch_lat", 64'(fl), 5);
      end else begin
        set_d(1'(kind == 1), s, w, a, wd);
        f_addr = fa;
        run(1, kind == 3, -1, -100, ds, dl, dr, fs, fl, fr);
        if (kind == 1) begin
          chk("rnd_store_lat", 64'(dl), 64'(n));
          check_writes(a, wd, n);
          ref_store(a, wd, n);
        end else begin
          chk("rnd_load_data", dr, ref_load(a, n, s));
          chk("rnd_load_lat", 64'(dl), 64'(n + 1));
        end
        if (kind == 3) begin
          chk("rnd_pair_fetch_data", fr, ref_load(fa, 4, 0));
          chk("rnd_pair_fetch_lat", 64'(fl), 64'(dl + 7));
        end
      end
    end

    chk("rdy_both_high", 64'(both_high), 0);
    chk("rdy_back_to_back", 64'(back_to_back), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
